// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that sequences fetch, decode,
// execute, memory and writeback steps. It drives ALU operation and operand
// selects, memory/IR/PC/register-file strobes, and counts retired instructions.
//
// Memory handshake: mem_read / mem_write are requests held high for every
// cycle of an access state. The access completes in the cycle where
// mem_ready=1, and the FSM advances on the clock edge that ends that cycle.
// Until then it waits in the same state with the same outputs.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [2:0]       alu_operation,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q;
    state_t     state_d;
    logic       retire;
    logic       r_legal;
    logic [2:0] r_op;

    assign state_dbg = state_q;

    // State register and retired-instruction counter (wraps naturally)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // R-type funct decode: ALU operation and legality
    always_comb begin
        r_legal = 1'b1;
        r_op    = ALU_ADD;
        case (funct)
            FN_ADD:  r_op = ALU_ADD;
            FN_SUB:  r_op = ALU_SUB;
            FN_AND:  r_op = ALU_AND;
            FN_OR:   r_op = ALU_OR;
            FN_SLT:  r_op = ALU_SLT;
            default: r_legal = 1'b0;
        endcase
    end

    // Next-state logic; retire marks the edge that completes an instruction
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW)      state_d = S_MEMWR;
                else if (opcode == OP_LW) state_d = S_MEMRD;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = r_legal ? S_ALUWB : S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore outputs per state; strobes and illegal are held low during reset
    always_comb begin
        alu_operation = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        pc_en         = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
                    default:                                   illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a     = 1'b1;
                alu_operation = r_op;
                illegal       = ~r_legal;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_operation = ALU_SUB;
                pc_src        = 2'b01;
                pc_en         = zero;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction summaries from a behavioural
// model are queued by the driver and compared by a monitor each time the
// controller returns to FETCH.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = '0;
    logic [5:0]       funct = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b1;
    logic [2:0]       alu_operation;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_operation(alu_operation), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal(illegal), .retired(retired), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [7:0] cycles;    // cycles from first FETCH cycle to next FETCH
        logic [3:0] ret;       // retired value once back in FETCH
        logic [3:0] ill;       // illegal pulses
        logic [3:0] rw;        // reg_write cycles
        logic [7:0] wr_cnt;    // mem_write cycles
        logic [7:0] rd_cnt;    // mem_read cycles
        logic [7:0] io_cnt;    // iord cycles
        logic [3:0] pcen;      // pc_en cycles
        logic [3:0] irw;       // ir_write cycles
        logic [5:0] ex;        // {src_a, src_b, alu_op} in the step after DECODE
        logic [1:0] wb;        // {reg_dst, mem_to_reg} while reg_write
        logic [1:0] pcs;       // pc_src while pc_en
        logic [7:0] ssum;      // sum of visited state numbers
    } rec_t;
    localparam int W = $bits(rec_t);

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int exp_ret  = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic bit op_known(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // returns 3'bxxx-free code; bit 3 set means the funct is unsupported
    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b1010;
        endcase
    endfunction

    function automatic rec_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input int fw, input int mw,
                                   input int ret_before);
        rec_t r;
        logic [3:0] ra;
        r = '0;
        r.irw    = 4'd1;
        r.pcen   = 4'd1;
        r.rd_cnt = 8'(fw + 1);
        case (op)
            OP_LW: begin
                r.cycles = 8'(5 + fw + mw);
                r.rd_cnt = 8'(fw + 1 + mw + 1);
                r.io_cnt = 8'(mw + 1);
                r.rw = 4'd1; r.wb = 2'b01;
                r.ex = 6'b110_010;
                r.ssum = 8'(1 + 2 + 3 * (mw + 1) + 4);
            end
            OP_SW: begin
                r.cycles = 8'(4 + fw + mw);
                r.wr_cnt = 8'(mw + 1);
                r.io_cnt = 8'(mw + 1);
                r.ex = 6'b110_010;
                r.ssum = 8'(1 + 2 + 5 * (mw + 1));
            end
            OP_R: begin
                ra = r_alu(fn);
                if (!ra[3]) begin
                    r.cycles = 8'(4 + fw);
                    r.rw = 4'd1; r.wb = 2'b10;
                    r.ex = {3'b100, ra[2:0]};
                    r.ssum = 8'd14;
                end else begin
                    r.cycles = 8'(3 + fw);
                    r.ill = 4'd1;
                    r.ex = 6'b100_010;
                    r.ssum = 8'd7;
                end
            end
            OP_BEQ: begin
                r.cycles = 8'(3 + fw);
                r.pcen = z ? 4'd2 : 4'd1;
                r.pcs = z ? 2'b01 : 2'b00;
                r.ex = 6'b100_110;
                r.ssum = 8'd9;
            end
            OP_J: begin
                r.cycles = 8'(3 + fw);
                r.pcen = 4'd2; r.pcs = 2'b10;
                r.ex = 6'b000_010;
                r.ssum = 8'd10;
            end
            OP_ADDI: begin
                r.cycles = 8'(4 + fw);
                r.rw = 4'd1; r.wb = 2'b00;
                r.ex = 6'b110_010;
                r.ssum = 8'd22;
            end
            default: begin
                r.cycles = 8'(2 + fw);
                r.ill = 4'd1;
                r.ssum = 8'd1;
            end
        endcase
        r.ret = (r.ill == 0) ? 4'((ret_before + 1) % 16) : 4'(ret_before);
        return r;
    endfunction

    // ---------------- driver ----------------
    // fw: FETCH wait cycles, mw: MEMRD/MEMWR wait cycles
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw);
        rec_t r;
        bit is_mem;
        r = model(op, fn, z, fw, mw, exp_ret);
        exp_q.push_back(W'(r));
        exp_ret = int'(r.ret);
        is_mem = (op == OP_LW) || (op == OP_SW);
        for (int c = 0; c < int'(r.cycles); c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            funct     = 6'($urandom);
            opcode    = (c <= fw) ? 6'($urandom) : op;
            if (c <= fw) mem_ready = (c == fw);
            if (is_mem && c >= fw + 3) mem_ready = (c == fw + 3 + mw);
            if (op == OP_R && c == fw + 2) funct = fn;
            if (op == OP_BEQ && c == fw + 2) zero = z;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- monitor ----------------
    int a_cyc, a_ill, a_rw, a_wr, a_rd, a_io, a_pcen, a_irw, a_ex, a_wb, a_pcs, a_ssum;
    logic [3:0] prev_st = 4'd0;

    task automatic clear_acc();
        a_cyc = 0; a_ill = 0; a_rw = 0; a_wr = 0; a_rd = 0; a_io = 0;
        a_pcen = 0; a_irw = 0; a_ex = 0; a_wb = 0; a_pcs = 0; a_ssum = 0;
    endtask

    task automatic complete_instr();
        rec_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_completion", 1, 0);
        end else begin
            e = rec_t'(exp_q.pop_front());
            chk("cycles", a_cyc, int'(e.cycles));
            chk("retired", int'(retired), int'(e.ret));
            chk("illegal_pulses", a_ill, int'(e.ill));
            chk("reg_write_cycles", a_rw, int'(e.rw));
            chk("mem_write_cycles", a_wr, int'(e.wr_cnt));
            chk("mem_read_cycles", a_rd, int'(e.rd_cnt));
            chk("iord_cycles", a_io, int'(e.io_cnt));
            chk("pc_en_cycles", a_pcen, int'(e.pcen));
            chk("ir_write_cycles", a_irw, int'(e.irw));
            chk("exec_src_aluop", a_ex, int'(e.ex));
            chk("wb_dst_memtoreg", a_wb, int'(e.wb));
            chk("pc_src", a_pcs, int'(e.pcs));
            chk("state_sum", a_ssum, int'(e.ssum));
        end
        clear_acc();
    endtask

    // Sample on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (state_dbg == 4'd0 && prev_st != 4'd0) complete_instr();
            a_cyc++;
            a_ssum += int'(state_dbg);
            if (illegal)   a_ill++;
            if (reg_write) a_rw++;
            if (mem_write) a_wr++;
            if (mem_read)  a_rd++;
            if (iord)      a_io++;
            if (pc_en)     a_pcen++;
            if (ir_write)  a_irw++;
            if (reg_write) a_wb |= int'({reg_dst, mem_to_reg});
            if (pc_en)     a_pcs |= int'(pc_src);
            if (prev_st == 4'd1 && state_dbg != 4'd0)
                a_ex = int'({alu_src_a, alu_src_b, alu_operation});
            if (state_dbg == 4'd0)
                chk("fetch_outputs",
                    int'({mem_read, alu_src_a, alu_src_b, iord, alu_operation, ir_write, pc_en}),
                    int'({1'b1, 1'b0, 2'b01, 1'b0, 3'b010, mem_ready, mem_ready}));
            if (state_dbg == 4'd1)
                chk("decode_outputs",
                    int'({alu_src_a, alu_src_b, alu_operation, mem_read, mem_write, reg_write}),
                    int'({1'b0, 2'b11, 3'b010, 1'b0, 1'b0, 1'b0}));
            prev_st = state_dbg;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] legal_fn [5];
        legal_fn[0] = 6'b100000; legal_fn[1] = 6'b100010; legal_fn[2] = 6'b100100;
        legal_fn[3] = 6'b100101; legal_fn[4] = 6'b101010;
        clear_acc();

        // reset state, with mem_ready high so FETCH strobes would fire if not gated
        #12;
        chk("reset_state", int'(state_dbg), 0);
        chk("reset_retired", int'(retired), 0);
        chk("reset_ir_write", int'(ir_write), 0);
        chk("reset_pc_en", int'(pc_en), 0);
        chk("reset_illegal", int'(illegal), 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // directed cases
        issue(OP_R,   6'b100000, 1'b0, 0, 0);   // add
        issue(OP_LW,  6'b000000, 1'b0, 0, 2);   // lw, two MEMRD waits
        issue(OP_BEQ, 6'b000000, 1'b1, 0, 0);   // taken
        issue(OP_BEQ, 6'b000000, 1'b0, 0, 0);   // not taken
        issue(6'b111111, 6'b000000, 1'b0, 0, 0); // illegal opcode
        issue(OP_R,   6'b000000, 1'b0, 0, 0);   // illegal funct
        issue(OP_SW,  6'b000000, 1'b0, 1, 1);
        issue(OP_J,   6'b000000, 1'b0, 2, 0);
        issue(OP_ADDI, 6'b000000, 1'b0, 0, 0);
        issue(OP_R,   6'b100010, 1'b0, 0, 0);   // sub
        issue(OP_R,   6'b101010, 1'b0, 1, 0);   // slt

        // random stream; long enough to wrap the 4-bit counter several times
        for (int i = 0; i < 60; i++) begin
            fn = legal_fn[$urandom_range(0, 4)];
            case ($urandom_range(0, 9))
                0: op = OP_LW;
                1: op = OP_SW;
                2, 3: op = OP_R;
                4: op = OP_BEQ;
                5: op = OP_J;
                6: op = OP_ADDI;
                7: begin
                    op = 6'($urandom);
                    while (op_known(op)) op = 6'($urandom);
                end
                8: begin op = OP_R; fn = 6'($urandom); end
                default: op = OP_R;
            endcase
            issue(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // idle in FETCH so the last instruction is closed out
        mem_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("queue_drained", exp_q.size(), 0);

        // asynchronous reset in the middle of a store
        mon_en = 1'b0;
        opcode = OP_SW; mem_ready = 1'b1;
        @(posedge clk); #1;  // DECODE
        mem_ready = 1'b0;
        @(posedge clk); #1;  // MEMADR
        @(posedge clk); #1;  // MEMWR, waiting
        chk("pre_reset_state", int'(state_dbg), 5);
        chk("pre_reset_mem_write", int'(mem_write), 1);
        chk("pre_reset_retired", int'(retired), exp_ret);
        #2;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("async_reset_mem_write", int'(mem_write), 0);
        chk("async_reset_state", int'(state_dbg), 0);
        chk("async_reset_retired", int'(retired), 0);
        chk("async_reset_strobes", int'({ir_write, pc_en, reg_write, illegal}), 0);
        #10;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU.
- Decodes opcode/funct, drives the 3-bit ALU operation code and operand selects, and sequences memory, register-file, IR and PC strobes.
- Consumes the ALU zero flag for beq and the memory ready handshake; counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps at 2^CNT_W).

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE until FETCH
funct  in  6  IR[5:0]
zero  in  1  ALU result==0, combinational from ALU
mem_ready  in  1  memory access complete this cycle
alu_operation  out  3  AND 000, OR 001, ADD 010, SUB 110, SLT 111
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00=reg B, 01=const 4, 10=signext imm, 11=signext imm<<2
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
pc_en  out  1  PC load (already merged with branch condition)
iord  out  1  0=PC address, 1=ALUOut address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
reg_write  out  1  register-file write
illegal  out  1  one-cycle pulse on unsupported opcode/funct
retired  out  CNT_W  instructions completed since reset
state_dbg  out  4  current state encoding

Behaviour:
- Opcodes:
  - R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
  - Funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
  - Encodings 12–15 are unreachable; if ever entered, go to FETCH next cycle.
- Default outputs in every state unless listed: alu_operation=ADD, all selects 0, all strobes 0.
- FETCH:
  - mem_read=1, iord=0, src_a=0, src_b=01, ADD, pc_src=00.
  - ir_write=pc_en=mem_ready.
  - Stay in FETCH while mem_ready=0; when mem_ready=1 go to DECODE.
- DECODE:
  - src_a=0, src_b=11, ADD (branch target into ALUOut).
  - Next state: lw/sw->MEMADR, R->EXEC, beq->BRANCH, j->JUMP, addi->ADDIEX.
  - Any other opcode: illegal=1 and go to FETCH.
- MEMADR: src_a=1, src_b=10, ADD. Next: lw->MEMRD, sw->MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready=1, then go to FETCH.
- EXEC:
  - src_a=1, src_b=00, alu_operation decoded from funct.
  - Unknown funct: illegal=1, alu_operation=ADD, go to FETCH (no writeback).
  - Otherwise go to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
- BRANCH: src_a=1, src_b=00, SUB, pc_src=01, pc_en=zero. Next: FETCH.
- JUMP: pc_src=10, pc_en=1. Next: FETCH.
- ADDIEX: src_a=1, src_b=10, ADD. Next: ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
- Latency in cycles, zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each wait state adds 1 cycle to FETCH/MEMRD/MEMWR.
- retired:
  - Increments by 1 on the clock edge leaving MEMWB, ALUWB, ADDIWB, BRANCH or JUMP.
  - Also increments leaving MEMWR when mem_ready=1.
  - Illegal instructions do not retire.
  - Wraps from all-ones to 0.
- Outputs are combinational from the state register (plus funct, zero, mem_ready). No output depends on opcode outside DECODE/MEMADR.
- Reset:
  - rst_n=0 immediately forces state=FETCH and retired=0, including mid-instruction.
  - While rst_n=0, pc_en, ir_write, mem_write and reg_write are forced 0, and illegal=0.
  - First FETCH access begins on the first clock edge after deassertion.
- mem_ready is ignored in states that do not access memory.

Test Plan:
- Reset, then R-type add (funct 100000) with mem_ready=1 -> states 0,1,6,7,0. EXEC alu_operation=010; ALUWB reg_write=1, reg_dst=1. retired=1 after 4 cycles.
- lw with mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. mem_read=1 and iord=1 throughout MEMRD. Total 7 cycles. MEMWB mem_to_reg=1.
- beq twice: once with zero=1 (pc_en=1, pc_src=01, alu_operation=110), once with zero=0 (pc_en=0). Both return to FETCH after 3 cycles; retired increments both times.
- Opcode 111111 -> illegal pulse for 1 cycle in DECODE, next state FETCH, retired unchanged. R-type funct 000000 -> illegal in EXEC, reg_write never asserted.
- Assert rst_n=0 asynchronously in MEMWR with mem_write=1 -> mem_write falls without a clock edge; state_dbg=0, retired=0.
- Preload/run so retired reaches 2^CNT_W-1 (bench with CNT_W=4, 15 instructions), retire one more -> retired=0.
